// File: rtl/riscv_defines_pkg.sv
// riscv_defines
//   Shared definitions for the string-op issue path: operator width and
//   codes, the issue FSM state type, the queued request record and a helper
//   that says which operators the downstream string-op unit implements.
package riscv_defines;

    localparam int unsigned STR_OP_WIDTH = 3;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

    typedef enum logic [1:0] {
        STR_IDLE,
        STR_EXEC,
        STR_WAIT,
        STR_RESP
    } str_issue_state_e;

    typedef struct packed {
        logic [STR_OP_WIDTH-1:0] op;
        logic [31:0]             operand;
        logic [4:0]              rd;
    } str_req_t;

    // Only UPPER and LOWER exist in the string-op unit; everything else is
    // answered locally with an error response.
    function automatic logic str_op_supported(input logic [STR_OP_WIDTH-1:0] op);
        return (op == STR_OP_UPPER) || (op == STR_OP_LOWER);
    endfunction

endpackage

// File: rtl/riscv_str_req_fifo.sv
// riscv_str_req_fifo
//   Small request buffer in front of the string-op issue FSM.
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : empties the buffer (wins over a same-edge push)
//   push_i/data_i : write one request
//   pop_i         : drop the head entry
//   full_o/empty_o: occupancy flags from the registered count
//   head_o        : oldest entry (valid when empty_o is 0)
module riscv_str_req_fifo
    import riscv_defines::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  logic     push_i,
    input  str_req_t data_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output str_req_t head_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    str_req_t          mem_q [DEPTH];
    str_req_t          mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_str_issue.sv
// riscv_str_issue
//   Queues string-op requests from EX, issues them one at a time to the
//   string-op unit and presents each result to writeback.
//   clk, rst                 : clock, synchronous active-high reset
//   flush_i                  : kill all queued and in-flight work
//   req_valid_i/req_ready_o  : request handshake; req_op_i, req_operand_i, req_rd_i
//   str_enable_o             : one-cycle issue strobe; str_operator_o, str_operand_o
//   str_result_i             : unit result, valid the cycle after the strobe
//   resp_valid_o/resp_ready_i: response handshake; resp_result_o, resp_rd_o, resp_err_o
//   busy_o                   : FSM not idle or requests queued
module riscv_str_issue
    import riscv_defines::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [STR_OP_WIDTH-1:0] req_op_i,
    input  logic [31:0]             req_operand_i,
    input  logic [4:0]              req_rd_i,
    output logic                    str_enable_o,
    output logic [STR_OP_WIDTH-1:0] str_operator_o,
    output logic [31:0]             str_operand_o,
    input  logic [31:0]             str_result_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [31:0]             resp_result_o,
    output logic [4:0]              resp_rd_o,
    output logic                    resp_err_o,
    output logic                    busy_o
);

    str_issue_state_e state_q, state_d;
    logic [31:0]      resp_result_q, resp_result_d;
    logic [4:0]       resp_rd_q, resp_rd_d;
    logic             resp_err_q, resp_err_d;

    logic     fifo_full, fifo_empty, fifo_push, fifo_pop;
    str_req_t fifo_head, fifo_data;
    logic     dispatch;

    assign fifo_data = '{op: req_op_i, operand: req_operand_i, rd: req_rd_i};
    assign fifo_push = req_valid_i & req_ready_o;

    riscv_str_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (fifo_data),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // IDLE and an accepted RESP share the same head-of-queue dispatch.
    assign dispatch = (state_q == STR_IDLE) || ((state_q == STR_RESP) && resp_ready_i);

    always_comb begin
        state_d       = state_q;
        resp_result_d = resp_result_q;
        resp_rd_d     = resp_rd_q;
        resp_err_d    = resp_err_q;
        fifo_pop      = 1'b0;

        if (dispatch) begin
            if (fifo_empty) begin
                state_d = STR_IDLE;
            end else if (str_op_supported(fifo_head.op)) begin
                state_d = STR_EXEC;
            end else begin
                // Unsupported operator: echo the operand back flagged as error.
                state_d       = STR_RESP;
                resp_result_d = fifo_head.operand;
                resp_rd_d     = fifo_head.rd;
                resp_err_d    = 1'b1;
                fifo_pop      = 1'b1;
            end
        end else begin
            case (state_q)
                STR_EXEC: state_d = STR_WAIT;
                STR_WAIT: begin
                    state_d       = STR_RESP;
                    resp_result_d = str_result_i;
                    resp_rd_d     = fifo_head.rd;
                    resp_err_d    = 1'b0;
                    fifo_pop      = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end

        if (flush_i) begin
            state_d  = STR_IDLE;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= STR_IDLE;
            resp_result_q <= '0;
            resp_rd_q     <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            resp_result_q <= resp_result_d;
            resp_rd_q     <= resp_rd_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready_o    = ~fifo_full;
    assign str_enable_o   = (state_q == STR_EXEC);
    assign str_operator_o = fifo_head.op;
    assign str_operand_o  = fifo_head.operand;
    assign resp_valid_o   = (state_q == STR_RESP);
    assign resp_result_o  = resp_result_q;
    assign resp_rd_o      = resp_rd_q;
    assign resp_err_o     = resp_err_q;
    assign busy_o         = (state_q != STR_IDLE) || ~fifo_empty;

endmodule

// File: tb/tb_riscv_str_issue.sv
// tb_riscv_str_issue
//   Directed bench for riscv_str_issue with a behavioural string-op unit.
module tb_riscv_str_issue;
    import riscv_defines::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush_i;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [STR_OP_WIDTH-1:0] req_op_i;
    logic [31:0]             req_operand_i;
    logic [4:0]              req_rd_i;
    logic                    str_enable_o;
    logic [STR_OP_WIDTH-1:0] str_operator_o;
    logic [31:0]             str_operand_o;
    logic [31:0]             str_result_i = 32'h0;
    logic                    resp_valid_o;
    logic                    resp_ready_i;
    logic [31:0]             resp_result_o;
    logic [4:0]              resp_rd_o;
    logic                    resp_err_o;
    logic                    busy_o;

    int checks   = 0;
    int failures = 0;
    int en_count = 0;

    riscv_str_issue #(.FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_operand_i  (req_operand_i),
        .req_rd_i       (req_rd_i),
        .str_enable_o   (str_enable_o),
        .str_operator_o (str_operator_o),
        .str_operand_o  (str_operand_o),
        .str_result_i   (str_result_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_result_o  (resp_result_o),
        .resp_rd_o      (resp_rd_o),
        .resp_err_o     (resp_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Behavioural string-op unit: registered case conversion of each byte.
    function automatic logic [31:0] str_model(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] v);
        logic [31:0] r;
        logic [7:0]  b;
        r = v;
        for (int i = 0; i < 4; i++) begin
            b = v[8*i +: 8];
            if (op == STR_OP_UPPER && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
            if (op == STR_OP_LOWER && b >= 8'h41 && b <= 8'h5A) b = b + 8'h20;
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        str_result_i <= str_enable_o ? str_model(str_operator_o, str_operand_o) : 32'hDEAD_BEEF;
        if (str_enable_o) en_count <= en_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0;
        req_operand_i = '0; req_rd_i = '0; resp_ready_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0h exp=0", resp_valid_o); end
        checks++; if (str_enable_o !== 1'b0) begin failures++; $display("FAIL reset_str_enable got=%0h exp=0", str_enable_o); end
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0h exp=1", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
        checks++; if ({resp_result_o, resp_rd_o, resp_err_o} !== 38'h0) begin failures++; $display("FAIL reset_resp_regs got=%h/%h/%h exp=0", resp_result_o, resp_rd_o, resp_err_o); end
    endtask

    task automatic test_upper();
        resp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h64636261; req_rd_i = 5'd5;
        tick();                                   // E0: accepted
        req_valid_i = 1'b0;
        checks++; if (str_enable_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL upper_e0 en=%0h busy=%0h exp en=0 busy=1", str_enable_o, busy_o); end
        tick();                                   // E1: EXEC
        checks++; if (str_enable_o !== 1'b1) begin failures++; $display("FAIL upper_enable got=%0h exp=1", str_enable_o); end
        checks++; if (str_operator_o !== STR_OP_UPPER || str_operand_o !== 32'h64636261) begin failures++; $display("FAIL upper_issue got=%0h/%h exp=0/64636261", str_operator_o, str_operand_o); end
        tick();                                   // E2: WAIT
        checks++; if (str_enable_o !== 1'b0 || resp_valid_o !== 1'b0) begin failures++; $display("FAIL upper_wait en=%0h valid=%0h exp 0/0", str_enable_o, resp_valid_o); end
        tick();                                   // E3: RESP
        checks++; if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL upper_valid got=%0h exp=1", resp_valid_o); end
        checks++; if (resp_result_o !== 32'h44434241 || resp_rd_o !== 5'd5 || resp_err_o !== 1'b0) begin failures++; $display("FAIL upper_resp got=%h/%0d/%0h exp=44434241/5/0", resp_result_o, resp_rd_o, resp_err_o); end
        tick();                                   // E4: consumed
        checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL upper_done valid=%0h busy=%0h exp 0/0", resp_valid_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res [3];
        logic [4:0]  exp_rd  [3];
        int          at      [3];
        int          got;
        exp_res[0] = 32'h61626364; exp_rd[0] = 5'd1;
        exp_res[1] = 32'h7A2D3161; exp_rd[1] = 5'd2;
        exp_res[2] = 32'h00FF6D6E; exp_rd[2] = 5'd3;
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_op_i = STR_OP_LOWER;
        req_operand_i = 32'h41424344; req_rd_i = 5'd1;
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0h exp=1", req_ready_o); end
        tick();
        req_operand_i = 32'h5A2D3141; req_rd_i = 5'd2;
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0h exp=1", req_ready_o); end
        tick();
        req_operand_i = 32'h00FF4D6E; req_rd_i = 5'd3;
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full got=%0h exp=0", req_ready_o); end
        tick();
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_still_full got=%0h exp=0", req_ready_o); end
        tick();                                   // first pop frees a slot
        checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_slot ready=%0h valid=%0h exp 1/1", req_ready_o, resp_valid_o); end
        tick();                                   // third accepted
        req_valid_i = 1'b0;
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_refull got=%0h exp=0", req_ready_o); end
        resp_ready_i = 1'b1;
        got = 0;
        for (int i = 0; i < 30 && got < 3; i++) begin
            if (resp_valid_o === 1'b1) begin
                checks++;
                if (resp_result_o !== exp_res[got] || resp_rd_o !== exp_rd[got] || resp_err_o !== 1'b0) begin
                    failures++; $display("FAIL b2b_resp%0d got=%h/%0d/%0h exp=%h/%0d/0", got, resp_result_o, resp_rd_o, resp_err_o, exp_res[got], exp_rd[got]);
                end
                at[got] = i;
                got++;
            end
            tick();
        end
        checks++; if (got != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got); end
        else begin
            checks++; if (at[1] - at[0] != 3 || at[2] - at[1] != 3) begin failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", at[1] - at[0], at[2] - at[1]); end
        end
        tick(); tick();
    endtask

    task automatic test_unsupported_hold();
        int en_base;
        logic [STR_OP_WIDTH-1:0] ops [2];
        resp_ready_i = 1'b0;
        en_base = en_count;
        req_valid_i = 1'b1; req_op_i = STR_OP_ROT13; req_operand_i = 32'h41424344; req_rd_i = 5'd7;
        tick();
        req_valid_i = 1'b0;
        tick();                                   // IDLE -> RESP directly
        checks++; if (resp_valid_o !== 1'b1 || str_enable_o !== 1'b0) begin failures++; $display("FAIL rot13_valid valid=%0h en=%0h exp 1/0", resp_valid_o, str_enable_o); end
        checks++; if (resp_result_o !== 32'h41424344 || resp_rd_o !== 5'd7 || resp_err_o !== 1'b1) begin failures++; $display("FAIL rot13_resp got=%h/%0d/%0h exp=41424344/7/1", resp_result_o, resp_rd_o, resp_err_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (resp_valid_o !== 1'b1 || resp_result_o !== 32'h41424344 || resp_rd_o !== 5'd7 || en_count != en_base) begin
                failures++; $display("FAIL hold_%0d valid=%0h res=%h rd=%0d en=%0d exp 1/41424344/7/%0d", i, resp_valid_o, resp_result_o, resp_rd_o, en_count, en_base);
            end
        end
        resp_ready_i = 1'b1;
        tick();
        checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL rot13_release valid=%0h busy=%0h exp 0/0", resp_valid_o, busy_o); end
        ops[0] = STR_OP_LEET; ops[1] = 3'd5;
        for (int k = 0; k < 2; k++) begin
            req_valid_i = 1'b1; req_op_i = ops[k]; req_operand_i = 32'h12345678 + k; req_rd_i = 5'd30 - 5'(k);
            tick();
            req_valid_i = 1'b0;
            tick();
            checks++;
            if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b1 || resp_result_o !== 32'h12345678 + k || resp_rd_o !== 5'd30 - 5'(k)) begin
                failures++; $display("FAIL unsup_op%0d valid=%0h err=%0h res=%h rd=%0d", k, resp_valid_o, resp_err_o, resp_result_o, resp_rd_o);
            end
            tick();
        end
        checks++; if (en_count != en_base) begin failures++; $display("FAIL unsup_no_enable got=%0d exp=%0d", en_count, en_base); end
    endtask

    task automatic test_flush();
        int seen_valid;
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_op_i = STR_OP_LOWER; req_operand_i = 32'h41414141; req_rd_i = 5'd4;
        tick();
        req_operand_i = 32'h42424242; req_rd_i = 5'd5;
        tick();
        req_valid_i = 1'b0;
        checks++; if (str_enable_o !== 1'b1) begin failures++; $display("FAIL flush_exec got=%0h exp=1", str_enable_o); end
        tick();                                   // WAIT; flush races a new push
        flush_i = 1'b1; req_valid_i = 1'b1; req_rd_i = 5'd6;
        tick();
        flush_i = 1'b0; req_valid_i = 1'b0;
        checks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL flush_state valid=%0h busy=%0h ready=%0h exp 0/0/1", resp_valid_o, busy_o, req_ready_o); end
        seen_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid_o !== 1'b0 || str_enable_o !== 1'b0) seen_valid++;
        end
        checks++; if (seen_valid != 0) begin failures++; $display("FAIL flush_quiet got=%0d exp=0", seen_valid); end
    endtask

    task automatic test_reset_mid();
        int waited;
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h64636261; req_rd_i = 5'd12;
        tick();
        req_valid_i = 1'b0;
        waited = 0;
        while (resp_valid_o !== 1'b1 && waited < 10) begin tick(); waited++; end
        checks++; if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL rstmid_reach got=%0h exp=1", resp_valid_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b0 || resp_result_o !== 32'h0 || resp_rd_o !== 5'd0 || resp_err_o !== 1'b0 ||
            str_enable_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs valid=%0h res=%h rd=%0d err=%0h en=%0h ready=%0h busy=%0h", resp_valid_o, resp_result_o, resp_rd_o, resp_err_o, str_enable_o, req_ready_o, busy_o);
        end
        resp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h7A797877; req_rd_i = 5'd9;
        tick();
        req_valid_i = 1'b0;
        waited = 0;
        while (resp_valid_o !== 1'b1 && waited < 10) begin tick(); waited++; end
        checks++; if (resp_valid_o !== 1'b1 || resp_result_o !== 32'h5A595857 || resp_rd_o !== 5'd9 || resp_err_o !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0h/%h/%0d/%0h exp=1/5a595857/9/0", resp_valid_o, resp_result_o, resp_rd_o, resp_err_o); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_upper();
        test_back_to_back();
        test_unsupported_hold();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
